db_dma: RTL and testbench
=========================

Name: db_dma

Overview:
- Bus initiator (DMA engine) on the CPU data-bus protocol from DataBus.vh. It drives db_addr, db_dataOut, db_accessType and db_io, and consumes db_dataIn and db_ready.
- Copies a block of 32-bit words from a source address to a destination address, without the CPU.
- Sits beside CPU_MMU in front of the shared memory responder. Bus arbitration is outside this block.

Parameters:
- LEN_W, 16, width of the word-count input.
- ADDR_STEP, 4, byte increment per word. Fixed word transfers.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request. Sampled only in IDLE.
- src  in  32  source byte address. Must be word aligned.
- dst  in  32  destination byte address. Must be word aligned.
- len  in  LEN_W  number of words to move.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at completion or error.
- err  out  1  set with done on a misaligned request. Cleared by the next accepted start.
- db_addr  out  32  bus address.
- db_dataOut  out  32  write data.
- db_dataIn  in  32  read data. Valid the cycle after the read request is accepted.
- db_accessType  out  `MEM_ACCESS  NONE/R/W encoding from DataBus.vh. X is never driven.
- db_io  out  1  constant 0. Memory space only.
- db_ready  in  1  responder accepts the current request at this rising edge.

Behaviour:
- Reset (clk edge with res=1):
  - state goes to IDLE.
  - busy=0, done=0, err=0, db_io=0, db_addr=0, db_dataOut=0, db_accessType=NONE.
  - Reset mid-transfer abandons the transfer. No done pulse. db_accessType is NONE from the next cycle.
- State machine states: IDLE, RD_REQ, RD_DATA, WR, DONE.
- IDLE, start=1:
  - latch src, dst and len into curSrc, curDst and cnt. Clear err.
  - If src[1:0]!=0 or dst[1:0]!=0: go to DONE with err=1. No bus traffic.
  - Else if len==0: go to DONE. No bus traffic.
  - Else go to RD_REQ.
- RD_REQ:
  - db_accessType=R, db_addr=curSrc.
  - Hold the request until an edge with db_ready=1, then go to RD_DATA.
- RD_DATA:
  - db_accessType=NONE.
  - Capture db_dataIn into the buffer, then go to WR.
- WR:
  - db_accessType=W, db_addr=curDst, db_dataOut=buffer.
  - On an edge with db_ready=1: curSrc+=4, curDst+=4, cnt-=1.
  - Then go to DONE if cnt was 1, else to RD_REQ.
- DONE: done=1 for exactly one cycle, busy=0 the following cycle, then go to IDLE.
- Latency:
  - With db_ready always 1, each word takes 3 cycles.
  - done is high in cycle 3N+1 counted from the start edge.
  - Each db_ready=0 cycle adds one cycle.
- Addresses wrap modulo 2^32. No error is raised on wrap.
- start while busy is ignored. src, dst and len are not re-sampled until IDLE.
- Outputs are registered. db_addr and db_dataOut hold their last value when db_accessType=NONE.

Optional Feature:
- Macro: DB_DMA_FILL_EN.
- Defined:
  - Adds inputs fill (1 bit) and fillData (32 bits), sampled with start.
  - fill=1 skips RD_REQ and RD_DATA. Each word goes IDLE to WR directly, writing fillData to curDst. src is ignored and its alignment is not checked.
  - Latency with db_ready=1 is N cycles, with done in cycle N+1.
- Undefined: the ports are absent and the block always copies.

Decomposition:
- MEM_ACCESS width and its NONE/R/W/X values stay in DataBus.vh, shared with CPU_MMU and the memory models. Not redefined here.
- State encodings are localparams inside db_dma.
- No sub-module. Counter and address increment logic is small enough to remain inline.

Test Plan:
- src=0x100, dst=0x200, len=4, memory word 0x100..0x10C = 0x11111111..0x44444444, db_ready=1:
  - four R then W pairs.
  - mem[0x200..0x20C] matches the source.
  - done in cycle 13, err=0.
- Same transfer with db_ready low for 2 cycles during the first R and 1 cycle during the last W:
  - request held stable while db_ready=0.
  - done in cycle 16. Data correct.
- len=0: done in cycle 1, err=0, db_accessType stays NONE throughout.
- src=0x102: done in cycle 1, err=1, no bus traffic. A following aligned start clears err.
- res=1 for one edge while in WR of word 2 of 4:
  - next cycle: busy=0, db_accessType=NONE, no done pulse.
  - only word 1 is written.
- With DB_DMA_FILL_EN: fill=1, fillData=0xDEADBEEF, dst=0x300, len=3:
  - three W only, no R.
  - mem[0x300..0x308]=0xDEADBEEF.
  - done in cycle 4.

Source files
------------

// File: rtl/db_dma_pkg.sv
// Shared bus-side definitions for the db_dma initiator: access-type encoding
// (mirrors the DataBus.vh MEM_ACCESS values) and word-stepping helpers.
package db_dma_pkg;

  localparam int MEM_ACCESS_W = 2;
  typedef logic [MEM_ACCESS_W-1:0] mem_access_t;

  localparam mem_access_t MEM_NONE = 2'd0;
  localparam mem_access_t MEM_R    = 2'd1;
  localparam mem_access_t MEM_W    = 2'd2;
  localparam mem_access_t MEM_X    = 2'd3;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/db_dma.sv
// Word-copy DMA initiator on the CPU data bus: read src, write dst, N words.
// Optional constant-fill mode is enabled by defining DB_DMA_FILL_EN.
module db_dma
  import db_dma_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
`ifdef DB_DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fillData,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      db_addr,
  output logic [31:0]      db_dataOut,
  input  logic [31:0]      db_dataIn,
  output mem_access_t      db_accessType,
  output logic             db_io,
  input  logic             db_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t           state_q, state_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      dout_q, dout_d;
  mem_access_t      acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // fill_in is the request-time flag; fill_mode is the latched per-transfer flag.
  logic             fill_in;
  logic             fill_mode;
  logic [31:0]      fill_word;

`ifdef DB_DMA_FILL_EN
  logic             fill_q, fill_d;
  logic [31:0]      fill_data_q, fill_data_d;

  assign fill_in   = fill;
  assign fill_mode = fill_q;
  assign fill_word = fill_data_q;

  always_comb begin
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    if (state_q == S_IDLE && start) begin
      fill_d      = fill;
      fill_data_d = fillData;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end
`else
  assign fill_in   = 1'b0;
  assign fill_mode = 1'b0;
  assign fill_word = '0;
`endif

  // NOTE: every always_comb target gets a hold/default value first so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_src_d = src;
          cur_dst_d = dst;
          cnt_d     = len;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          if (misaligned(dst) || (!fill_in && misaligned(src))) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (fill_in) begin
            state_d = S_WR;
            acc_d   = MEM_W;
            addr_d  = dst;
`ifdef DB_DMA_FILL_EN
            dout_d  = fillData;
`endif
          end else begin
            state_d = S_RD_REQ;
            acc_d   = MEM_R;
            addr_d  = src;
          end
        end
      end

      S_RD_REQ: begin
        if (db_ready) begin
          state_d = S_RD_DATA;
          acc_d   = MEM_NONE;
        end
      end

      // Read data is valid only in this cycle; it goes straight to the write bus.
      S_RD_DATA: begin
        state_d = S_WR;
        acc_d   = MEM_W;
        addr_d  = cur_dst_q;
        dout_d  = db_dataIn;
      end

      S_WR: begin
        if (db_ready) begin
          cur_src_d = cur_src_q + STEP;
          cur_dst_d = cur_dst_q + STEP;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DONE;
            acc_d   = MEM_NONE;
            done_d  = 1'b1;
          end else if (fill_mode) begin
            acc_d   = MEM_W;
            addr_d  = cur_dst_q + STEP;
            dout_d  = fill_word;
          end else begin
            state_d = S_RD_REQ;
            acc_d   = MEM_R;
            addr_d  = cur_src_q + STEP;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        acc_d   = MEM_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the datapath registers are reset as well, because db_addr and
  // db_dataOut are driven straight from them and must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      acc_q     <= MEM_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign db_addr       = addr_q;
  assign db_dataOut    = dout_q;
  assign db_accessType = acc_q;
  assign db_io         = 1'b0;

endmodule

// File: tb/tb_db_dma.sv
// Directed bench for db_dma: memory responder model, write scoreboard and
// cycle-accurate done timing. Define DB_DMA_FILL_EN to also cover fill mode.
module tb_db_dma;
  import db_dma_pkg::*;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, err;
  logic [31:0] db_addr, db_dataOut;
  logic [31:0] db_dataIn;
  logic [1:0]  db_accessType;
  logic        db_io;
  logic        db_ready;
`ifdef DB_DMA_FILL_EN
  logic        fill;
  logic [31:0] fill_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [63:0] exp_q [$];
  int          stall [$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          traffic = 0;
  logic        stall_prev = 1'b0;
  logic [1:0]  prev_type;
  logic [31:0] prev_addr, prev_data;

  db_dma dut (
    .clk           (clk),
    .res           (res),
    .start         (start),
    .src           (src),
    .dst           (dst),
    .len           (len),
`ifdef DB_DMA_FILL_EN
    .fill          (fill),
    .fillData      (fill_data),
`endif
    .busy          (busy),
    .done          (done),
    .err           (err),
    .db_addr       (db_addr),
    .db_dataOut    (db_dataOut),
    .db_dataIn     (db_dataIn),
    .db_accessType (db_accessType),
    .db_io         (db_io),
    .db_ready      (db_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: read data appears the cycle after the accepted request.
  always @(posedge clk) begin
    if (db_accessType == MEM_R && db_ready)
      db_dataIn <= mem.exists(db_addr) ? mem[db_addr] : 32'h0;
    if (!res && db_accessType == MEM_W && db_ready)
      mem[db_addr] = db_dataOut;
  end

  // Bus monitor: request stability under stall, and scoreboard of writes.
  always @(negedge clk) begin
    if (res) begin
      stall_prev = 1'b0;
    end else begin
      if (db_accessType != MEM_NONE) traffic++;
      if (stall_prev) begin
        check("hold_type", {30'h0, db_accessType}, {30'h0, prev_type});
        check("hold_addr", db_addr, prev_addr);
        if (prev_type == MEM_W) check("hold_data", db_dataOut, prev_data);
      end
      if (db_accessType == MEM_R && db_ready) rd_cnt++;
      if (db_accessType == MEM_W && db_ready) begin
        wr_cnt++;
        check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wr_addr", db_addr, e[63:32]);
          check("wr_data", db_dataOut, e[31:0]);
        end
      end
      stall_prev = (db_accessType != MEM_NONE) && !db_ready;
      prev_type  = db_accessType;
      prev_addr  = db_addr;
      prev_data  = db_dataOut;
    end
  end

  task automatic set_ready(input int c);
    db_ready = 1'b1;
    foreach (stall[i]) if (stall[i] == c) db_ready = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic f, input int exp_done,
                          input logic exp_err, output int rd_d, output int wr_d,
                          output int tr_d);
    int c;
    int done_at;
    int rd0, wr0, tr0;
    rd0 = rd_cnt; wr0 = wr_cnt; tr0 = traffic;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
`ifdef DB_DMA_FILL_EN
    fill = f;
`endif
    if (f) begin end
    @(posedge clk);
    #1 start = 1'b0;
    c = 1;
    set_ready(c);
    done_at = -1;
    while (c <= 200) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_busy_c1"}, {31'h0, busy}, 32'd1);
        if (!exp_err) check({tag, "_err_cleared"}, {31'h0, err}, 32'd0);
      end
      if (done) begin
        done_at = c;
        break;
      end
      @(posedge clk);
      #1 c++;
      set_ready(c);
    end
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    @(posedge clk);
    #1 db_ready = 1'b1;
    @(negedge clk);
    check({tag, "_busy_after"}, {31'h0, busy}, 32'd0);
    check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    rd_d = rd_cnt - rd0;
    wr_d = wr_cnt - wr0;
    tr_d = traffic - tr0;
  endtask

  initial begin
    int rd_d, wr_d, tr_d;
    int done_seen;
    res = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; db_ready = 1'b1;
`ifdef DB_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    for (int i = 0; i < 4; i++) mem[32'h100 + 4*i] = 32'h1111_1111 * (i + 1);

    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_err",  {31'h0, err},  32'd0);
    check("rst_type", {30'h0, db_accessType}, {30'h0, MEM_NONE});
    check("rst_addr", db_addr, 32'h0);
    check("rst_dout", db_dataOut, 32'h0);
    check("rst_io",   {31'h0, db_io}, 32'd0);

    // Straight copy, no stalls.
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h200 + 4*i, 32'h1111_1111 * (i + 1)});
    run_xfer("copy", 32'h100, 32'h200, 16'd4, 1'b0, 13, 1'b0, rd_d, wr_d, tr_d);
    check("copy_reads", rd_d, 32'd4);
    check("copy_writes", wr_d, 32'd4);
    for (int i = 0; i < 4; i++) check("copy_mem", mem[32'h200 + 4*i], 32'h1111_1111 * (i + 1));

    // Same copy with stalls in the first read and the last write.
    stall = '{1, 2, 14};
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h600 + 4*i, 32'h1111_1111 * (i + 1)});
    run_xfer("stall", 32'h100, 32'h600, 16'd4, 1'b0, 16, 1'b0, rd_d, wr_d, tr_d);
    stall = {};
    for (int i = 0; i < 4; i++) check("stall_mem", mem[32'h600 + 4*i], 32'h1111_1111 * (i + 1));

    run_xfer("len0", 32'h100, 32'h700, 16'd0, 1'b0, 1, 1'b0, rd_d, wr_d, tr_d);
    check("len0_traffic", tr_d, 32'd0);

    run_xfer("misal", 32'h102, 32'h800, 16'd2, 1'b0, 1, 1'b1, rd_d, wr_d, tr_d);
    check("misal_traffic", tr_d, 32'd0);

    exp_q.push_back({32'h500, 32'h4444_4444});
    run_xfer("realign", 32'h10C, 32'h500, 16'd1, 1'b0, 4, 1'b0, rd_d, wr_d, tr_d);
    check("realign_mem", mem[32'h500], 32'h4444_4444);

    // Reset while word 2 is stalled in its write cycle.
    exp_q.push_back({32'h400, 32'h1111_1111});
    done_seen = 0;
    @(negedge clk);
    src = 32'h100; dst = 32'h400; len = 16'd4; start = 1'b1;
`ifdef DB_DMA_FILL_EN
    fill = 1'b0;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      db_ready = (c != 6);
      if (c == 6) res = 1'b1;
      @(negedge clk);
      if (done) done_seen++;
      if (c < 6) @(posedge clk);
      if (c < 6) #1;
    end
    @(posedge clk);
    #1 res = 1'b0; db_ready = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'h0, busy}, 32'd0);
    check("rstmid_type", {30'h0, db_accessType}, {30'h0, MEM_NONE});
    for (int i = 0; i < 5; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("rstmid_no_done", done_seen, 32'd0);
    check("rstmid_word1", mem[32'h400], 32'h1111_1111);
    check("rstmid_word2_absent", {31'h0, mem.exists(32'h404)}, 32'd0);
    check("rstmid_sb_empty", exp_q.size(), 32'd0);

`ifdef DB_DMA_FILL_EN
    fill_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) exp_q.push_back({32'h300 + 4*i, 32'hDEAD_BEEF});
    run_xfer("fill", 32'h103, 32'h300, 16'd3, 1'b1, 4, 1'b0, rd_d, wr_d, tr_d);
    check("fill_reads", rd_d, 32'd0);
    check("fill_writes", wr_d, 32'd3);
    for (int i = 0; i < 3; i++) check("fill_mem", mem[32'h300 + 4*i], 32'hDEAD_BEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
